// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// active-low hex glyph table (g..a, bit0 = a) and idle output codes.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (g..a).
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with shadow/display double buffering,
// anode guard time and leading-zero blanking. Outputs are registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        en,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        ack
);

  localparam int             CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GRD     = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_q, sh_d, disp_q, disp_d;
  logic [3:0]    shdp_q, shdp_d, ddp_q, ddp_d;
  logic          pend_q, pend_d;
  logic          ack_q, ack_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick, frame_bnd, commit;
  logic [3:0]    cur_hex;
  logic [6:0]    glyph;
  logic          cur_dp, lz_blank;

  hex7_decode u_dec (
    .hex   (cur_hex),
    .seg_n (glyph)
  );

  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    frame_bnd = tick && (idx_q == 2'd3);
    // A load on the committing boundary bypasses the shadow straight to display.
    commit    = frame_bnd && (pend_q || load);

    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;

    sh_d   = load ? data  : sh_q;
    shdp_d = load ? dp_in : shdp_q;
    pend_d = frame_bnd ? 1'b0 : (pend_q || load);
    disp_d = commit ? sh_d   : disp_q;
    ddp_d  = commit ? shdp_d : ddp_q;
    ack_d  = commit;

    cur_hex  = disp_q[{idx_q, 2'b00} +: 4];
    cur_dp   = ddp_q[idx_q];
    // Digit k is a leading zero when digits 3..k are all zero.
    lz_blank = blank_lz && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0);

    an_d  = (!en || (cnt_q < GRD)) ? AN_OFF : ~(4'b0001 << idx_q);
    seg_d = en ? {~cur_dp, (lz_blank ? 7'h7F : glyph)} : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      shdp_q <= '0;
      disp_q <= '0;
      ddp_q  <= '0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      shdp_q <= shdp_d;
      disp_q <= disp_d;
      ddp_q  <= ddp_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign ack = ack_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-indexed reference model,
// table-driven display vectors, random traffic and hand-written corner cases.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int GD = 1;

  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0, en = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        ack;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .en(en), .seg(seg), .an(an), .ack(ack)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference state: time since reset release in cycles, plus buffer contents.
  int          m_cyc;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_ddp;
  logic        m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_ack;
  int          last_c, last_d, ack_cnt;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_ddp = '0; m_pend = 1'b0;
  endtask

  // Outputs after an edge are selected by the count/digit that held before it.
  task automatic model_edge();
    int  c, d;
    bit  fb, blank;
    c  = m_cyc % SD;
    d  = (m_cyc / SD) % 4;
    fb = (c == SD - 1) && (d == 3);
    blank = blank_lz && (d > 0);
    for (int j = 0; j < 4; j++)
      if (j >= d && m_disp[4*j +: 4] != 4'h0) blank = 1'b0;
    e_an  = (!en || c < GD) ? 4'hF : ~(4'b0001 << d);
    e_seg = !en ? 8'hFF : {~m_ddp[d], (blank ? 7'h7F : glyph(m_disp[4*d +: 4]))};
    e_ack = fb && (m_pend || load);
    if (load) begin m_sh = data; m_shdp = dp_in; end
    if (e_ack) begin m_disp = m_sh; m_ddp = m_shdp; end
    m_pend = fb ? 1'b0 : (m_pend || load);
    last_c = c; last_d = d;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("ack", ack, e_ack);
    if (ack) ack_cnt++;
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 16 && (m_cyc % 16) != phase; i++) step();
  endtask

  vec_t vecs[5];

  initial begin
    logic [3:0][7:0] got;
    bit got_ack;
    int ones;

    vecs[0] = '{data: 16'h1234, dp: 4'b0000, blz: 1'b0, exp: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{data: 16'h00A5, dp: 4'b0000, blz: 1'b1, exp: {8'hFF, 8'hFF, 8'h88, 8'h92}};
    vecs[2] = '{data: 16'h0000, dp: 4'b0000, blz: 1'b1, exp: {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{data: 16'hBEEF, dp: 4'b0101, blz: 1'b0, exp: {8'h83, 8'h06, 8'h86, 8'h0E}};
    vecs[4] = '{data: 16'h0080, dp: 4'b1000, blz: 1'b1, exp: {8'h7F, 8'hFF, 8'h80, 8'hC0}};

    // Reset state
    #12;
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", an, 4'hF);
    chk("reset_ack", ack, 1'b0);
    rst_n = 1'b1;
    model_reset();
    ack_cnt = 0;

    // Table-driven display content
    foreach (vecs[v]) begin
      blank_lz = vecs[v].blz; data = vecs[v].data; dp_in = vecs[v].dp; load = 1'b1;
      step();
      load = 1'b0;
      got_ack = ack;
      for (int i = 0; i < 40 && !got_ack; i++) begin
        step();
        got_ack = ack;
      end
      chk("vec_ack_seen", got_ack, 1'b1);
      got = '0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (last_c >= GD) got[last_d] = seg;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_digit%0d", v, k), got[k], vecs[v].exp[k]);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      data  = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      en    = ($urandom_range(0, 9) != 0);
      step();
    end
    load = 1'b0; en = 1'b1; blank_lz = 1'b0;

    // Flush to a known all-zero display
    data = 16'h0000; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Two loads within one frame: single ack, the first value never shown
    ack_cnt = 0; ones = 0;
    align(1);
    data = 16'h1111; load = 1'b1; step(); load = 1'b0;
    step(); step();
    data = 16'h2222; load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (an != 4'hF && seg[6:0] == 7'b1111001) ones++;
    end
    chk("double_load_acks", ack_cnt, 1);
    chk("double_load_no_1111", ones, 0);

    // Load exactly on the frame-boundary tick
    ack_cnt = 0;
    align(15);
    data = 16'hBEEF; load = 1'b1; step(); load = 1'b0;
    chk("boundary_load_ack", ack, 1'b1);
    for (int i = 0; i < 30; i++) step();
    chk("boundary_load_acks", ack_cnt, 1);

    // Display disabled mid-frame
    align(5);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dark_an", an, 4'hF);
      chk("dark_seg", seg, 8'hFF);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Asynchronous reset mid-dwell with a pending load
    align(2);
    data = 16'h5678; load = 1'b1; step(); load = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_ack", ack, 1'b0);
    #3 rst_n = 1'b1;
    model_reset();
    ack_cnt = 0;
    step(); step();
    chk("post_rst_digit0", seg, 8'hC0);
    chk("post_rst_an0", an, 4'hE);
    for (int i = 0; i < 40; i++) step();
    chk("post_rst_no_ack", ack_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit dwell (min 4).
REQ-002 SHALL have parameter GUARD, default 8, cycles at the start of each dwell with all anodes off (GUARD < SCAN_DIV).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load  input  1  one-cycle strobe; capture data/dp_in into shadow register.
REQ-006 SHALL have port data  input  16  four hex digits; digit k = data[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port dp_in  input  4  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_lz  input  1  1 = blank leading zero digits.
REQ-009 SHALL have port en  input  1  0 = display dark (scan continues).
REQ-010 SHALL have port seg  output  8  active-low; seg[6:0] = segments g..a (bit0 = a), seg[7] = dp.
REQ-011 SHALL have port an  output  4  active-low anode select, an[k] = digit k.
REQ-012 SHALL have port ack  output  1  one-cycle pulse when shadow is committed to display register.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = count == SCAN_DIV-1.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on tick; frame boundary = tick with index 3.
REQ-015 load SHALL write shadow register and set pending; load while pending SHALL overwrite shadow, with no extra ack.
REQ-016 At frame boundary with pending set, display register SHALL take the shadow value, pending SHALL clear, and ack SHALL pulse high on the following cycle only.
REQ-017 load coinciding with the committing frame boundary SHALL commit the new load value (shadow write bypasses to the display register) and leave pending clear.
REQ-018 Display SHALL never show a mix of old and new values within one frame.
REQ-019 an SHALL be 4'hF while prescaler count < GUARD; otherwise an = ~(1 << index).
REQ-020 seg SHALL be registered; outputs SHALL change exactly one cycle after the index/count that selects them.
REQ-021 Hex decode (active-low, g..a) SHALL be: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; remaining digits use the standard 7-segment glyphs.
REQ-022 Digit k>0 SHALL be blanked (seg[6:0] = 7'h7F) when blank_lz = 1 and digits 3..k are all zero; digit 0 SHALL never be blanked.
REQ-023 dp SHALL follow the latched dp value even on a blanked digit.
REQ-024 en = 0 SHALL force an = 4'hF and seg = 8'hFF; prescaler, index, commit and ack SHALL operate unchanged.

Reset
REQ-025 rst_n low SHALL asynchronously force seg = 8'hFF, an = 4'hF, ack = 0, prescaler = 0, index = 0, shadow = 0, display register = 0, and pending = 0.
REQ-026 Reset mid-frame SHALL discard pending data; first dwell after release SHALL be digit 0 starting at count 0.
REQ-027 Release of rst_n SHALL be the only synchronising assumption; no output may glitch low during reset.

Structure
REQ-028 Shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table, NUM_DIGITS = 4, and SEG_OFF = 8'hFF / AN_OFF = 4'hF constants.
REQ-029 One sub-module hex7_decode (4-bit in, 7-bit active-low out, combinational) SHALL be instantiated once on the muxed digit.
REQ-030 Prescaler, index, shadow/pending, and output registers SHALL reside in seg_scan_driver.

Verification (SCAN_DIV = 4, GUARD = 1)
REQ-031 Reset, then load data = 16'h1234, dp_in = 0 -> ack one cycle after the first frame boundary; subsequent dwells show an = E,D,B,7 with seg[6:0] = 4,3,2,1 glyphs; an = F during each guard cycle.
REQ-032 Load 16'h00A5 with blank_lz = 1 -> digits 3,2 seg = 8'hFF (dp 0), digit 1 = A, digit 0 = 5; load 16'h0000 -> only digit 0 shows 0 (1000000).
REQ-033 Two loads (16'h1111, then 16'h2222) within one frame -> single ack; display shows 2222; no frame shows 1111.
REQ-034 load asserted exactly on the frame-boundary tick with 16'hBEEF -> next frame shows BEEF; pending = 0; one ack.
REQ-035 en = 0 for 10 cycles mid-frame -> an = F, seg = FF during those cycles; index sequence resumes without a phase shift when en returns to 1.
REQ-036 rst_n low mid-dwell with pending set -> outputs FF/F immediately (asynchronously); after release, no ack; display shows 0000 (digit 0 glyph 1000000).
